// File: rtl/mau_host_sequencer.sv
// mau_host_sequencer: turns a host byte stream (instruction byte, optional
//   N-byte payload) into MAU issue/stream/capture cycles and reads store
//   results back to the host, one transfer in flight at a time.
// Latency: instruction issued the cycle after the last input byte (unless the
//   MAU is busy); the stream/capture window opens the cycle right after issue.
// Backpressure: s_ready drops for the whole transfer; readback holds m_data
//   stable until m_ready; issue stalls while busy_flag is high.
// Ports:
//   clk, rst (sync, active-low)   | s_valid/s_data/s_ready  host -> sequencer
//   m_valid/m_data/m_ready        sequencer -> host readback
//   host_instruction/data_in      sequencer -> MAU
//   busy_flag/data_out            MAU -> sequencer
//   seq_busy                      high whenever not IDLE
module mau_host_sequencer #(
  parameter int MATRIX_DIM = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  input  logic       m_ready,
  output logic [7:0] host_instruction,
  output logic [7:0] data_in,
  input  logic       busy_flag,
  input  logic [7:0] data_out,
  output logic       seq_busy
);

  localparam int N  = MATRIX_DIM * MATRIX_DIM;
  localparam int CW = $clog2(N) + 1;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [7:0] NOP = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_STREAM,
    S_CAPTURE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_instr;
  logic [7:0]    r_buf [N];

  logic [AW-1:0] w_idx;
  logic          w_s_fire;
  logic          w_m_fire;
  logic          w_issue;
  logic          w_cnt_last;

  // cnt only reaches N after the last FILL beat, and ISSUE clears it before
  // any indexed use, so the low bits are always a valid buffer address.
  assign w_idx      = r_cnt[AW-1:0];
  assign w_cnt_last = (r_cnt == LAST);

  // Every host/MAU-facing output is forced idle while rst is low so an
  // aborted transfer produces no stray beat in the reset cycle itself.
  assign s_ready          = rst && ((r_state == S_IDLE) || (r_state == S_FILL));
  assign w_s_fire         = s_valid && s_ready;
  assign w_issue          = rst && (r_state == S_ISSUE) && !busy_flag;
  assign host_instruction = w_issue ? r_instr : NOP;
  assign data_in          = (rst && (r_state == S_STREAM)) ? r_buf[w_idx] : 8'h00;
  assign m_valid          = rst && (r_state == S_DRAIN);
  assign m_data           = m_valid ? r_buf[w_idx] : 8'h00;
  assign w_m_fire         = m_valid && m_ready;
  assign seq_busy         = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_instr <= NOP;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_s_fire) begin
            r_instr <= s_data;
            r_cnt   <= '0;
            case (s_data[7:6])
              2'b11:   r_state <= S_IDLE;
              2'b01:   r_state <= S_FILL;
              default: r_state <= S_ISSUE;
            endcase
          end
        end
        S_FILL: begin
          if (w_s_fire) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_cnt_last) begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (!busy_flag) begin
            r_cnt <= '0;
            case (r_instr[7:6])
              2'b01:   r_state <= S_STREAM;
              2'b10:   r_state <= S_CAPTURE;
              default: r_state <= S_WAIT;
            endcase
          end
        end
        S_STREAM: begin
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_m_fire) begin
            if (w_cnt_last) begin
              r_cnt   <= '0;
              r_state <= S_WAIT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (!busy_flag) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Shared matrix buffer: written by host bytes in FILL, by the MAU in
  // CAPTURE. Contents need no reset.
  always_ff @(posedge clk) begin
    if ((r_state == S_FILL) && w_s_fire) begin
      r_buf[w_idx] <= s_data;
    end else if (rst && (r_state == S_CAPTURE)) begin
      r_buf[w_idx] <= data_out;
    end
  end

endmodule

// File: tb/tb_mau_host_sequencer.sv
// tb_mau_host_sequencer: self-checking bench for mau_host_sequencer with
//   MATRIX_DIM=2 (N=4): cycle vector table, directed multi-cycle sequences,
//   then random traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mau_host_sequencer;

  localparam int DIM = 2;
  localparam int N   = DIM * DIM;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [7:0] host_instruction;
  logic [7:0] data_in;
  logic       busy_flag;
  logic [7:0] data_out;
  logic       seq_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mau_host_sequencer #(.MATRIX_DIM(DIM)) dut (
    .clk              (clk),
    .rst              (rst),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_ready          (s_ready),
    .m_valid          (m_valid),
    .m_data           (m_data),
    .m_ready          (m_ready),
    .host_instruction (host_instruction),
    .data_in          (data_in),
    .busy_flag        (busy_flag),
    .data_out         (data_out),
    .seq_busy         (seq_busy)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: inputs change just after the rising edge, outputs are then
  // sampled at the falling edge.
  task automatic drive(input logic r, input logic sv, input logic [7:0] sd,
                       input logic bz, input logic mr, input logic [7:0] dout);
    @(posedge clk);
    #1;
    rst       = r;
    s_valid   = sv;
    s_data    = sd;
    busy_flag = bz;
    m_ready   = mr;
    data_out  = dout;
    @(negedge clk);
  endtask

  typedef struct {
    logic       r;
    logic       sv;
    logic [7:0] sd;
    logic       bz;
    logic       e_srdy;
    logic [7:0] e_hi;
    logic [7:0] e_di;
    logic       e_mv;
    logic       e_sb;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic sv, input logic [7:0] sd, input logic bz,
                              input logic er, input logic [7:0] eh, input logic [7:0] ed,
                              input logic em, input logic eb);
    vec_t v;
    v.r = r; v.sv = sv; v.sd = sd; v.bz = bz;
    v.e_srdy = er; v.e_hi = eh; v.e_di = ed; v.e_mv = em; v.e_sb = eb;
    vecs.push_back(v);
  endfunction

  // Random-phase reference model state.
  logic [7:0] bytes_q[$];
  logic [7:0] exp_issue[$];
  logic [7:0] exp_load[$];
  logic [7:0] exp_m[$];
  logic [7:0] st_b [4];

  initial begin
    int         idx;
    int         pend;
    logic [1:0] mode;
    logic       fired;
    logic       done;
    logic [1:0] cls;
    logic [7:0] ins;

    rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; busy_flag = 1'b0;
    m_ready = 1'b0; data_out = 8'h00;
    repeat (2) @(posedge clk);

    // ---------------- cycle table ----------------
    //   rst sv  sd     bz | srdy hi     di     mv sb
    add(L, L, 8'h00, L,   L, 8'hFF, 8'h00, L, L);  // in reset
    add(H, H, 8'h41, L,   H, 8'hFF, 8'h00, L, L);  // IDLE takes load
    add(H, H, 8'h01, L,   H, 8'hFF, 8'h00, L, H);  // FILL
    add(H, H, 8'h02, L,   H, 8'hFF, 8'h00, L, H);
    add(H, H, 8'h03, L,   H, 8'hFF, 8'h00, L, H);
    add(H, H, 8'h04, L,   H, 8'hFF, 8'h00, L, H);
    add(H, L, 8'h00, L,   L, 8'h41, 8'h00, L, H);  // ISSUE
    add(H, L, 8'h00, L,   L, 8'hFF, 8'h01, L, H);  // STREAM
    add(H, L, 8'h00, L,   L, 8'hFF, 8'h02, L, H);
    add(H, L, 8'h00, L,   L, 8'hFF, 8'h03, L, H);
    add(H, L, 8'h00, L,   L, 8'hFF, 8'h04, L, H);
    add(H, L, 8'h00, L,   L, 8'hFF, 8'h00, L, H);  // WAIT (min 1 cycle)
    add(H, H, 8'h03, L,   H, 8'hFF, 8'h00, L, L);  // IDLE takes compute
    for (int i = 0; i < 5; i++)
      add(H, L, 8'h00, H, L, 8'hFF, 8'h00, L, H);  // ISSUE blocked by busy
    add(H, L, 8'h00, L,   L, 8'h03, 8'h00, L, H);  // issue once busy clears
    add(H, L, 8'h00, L,   L, 8'hFF, 8'h00, L, H);  // WAIT
    add(H, H, 8'hC0, L,   H, 8'hFF, 8'h00, L, L);  // NOP offered
    add(H, L, 8'h00, L,   H, 8'hFF, 8'h00, L, L);  // NOP discarded

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].sv, vecs[i].sd, vecs[i].bz, L, 8'h00);
      chk1($sformatf("vec%0d s_ready", i), s_ready, vecs[i].e_srdy);
      chk($sformatf("vec%0d host_instruction", i), host_instruction, vecs[i].e_hi);
      chk($sformatf("vec%0d data_in", i), data_in, vecs[i].e_di);
      chk1($sformatf("vec%0d m_valid", i), m_valid, vecs[i].e_mv);
      chk1($sformatf("vec%0d seq_busy", i), seq_busy, vecs[i].e_sb);
    end

    // ---------------- store with readback backpressure ----------------
    st_b[0] = 8'h0A; st_b[1] = 8'h0B; st_b[2] = 8'h0C; st_b[3] = 8'h0D;
    drive(H, H, 8'h82, L, L, 8'h00);
    chk1("store accept s_ready", s_ready, H);
    drive(H, L, 8'h00, L, L, 8'h00);
    chk("store issue", host_instruction, 8'h82);
    for (int k = 0; k < N; k++) begin
      drive(H, L, 8'h00, L, L, st_b[k]);
      chk1($sformatf("capture%0d m_valid", k), m_valid, L);
      chk1($sformatf("capture%0d s_ready", k), s_ready, L);
    end
    idx = 0;
    for (int k = 0; k < 16 && idx < N; k++) begin
      drive(H, L, 8'h00, L, ((k % 2) == 0), 8'hEE);
      chk1($sformatf("drain%0d m_valid", k), m_valid, H);
      chk($sformatf("drain%0d m_data", k), m_data, st_b[idx]);
      if (m_ready) idx++;
    end
    chk_int("drain beats completed", idx, N);
    drive(H, L, 8'h00, L, H, 8'h00);
    chk1("after drain m_valid", m_valid, L);
    chk1("after drain seq_busy", seq_busy, H);
    drive(H, L, 8'h00, L, L, 8'h00);
    chk1("store back to idle", seq_busy, L);

    // ---------------- NOP then load with s_valid gaps ----------------
    drive(H, H, 8'hC0, L, L, 8'h00);
    chk("nop no issue", host_instruction, 8'hFF);
    drive(H, H, 8'h40, L, L, 8'h00);
    chk1("gap load accepted", s_ready, H);
    for (int b = 0; b < N; b++) begin
      drive(H, L, 8'h00, L, L, 8'h00);
      chk($sformatf("gap%0d no issue", b), host_instruction, 8'hFF);
      drive(H, H, 8'(8'h05 + b), L, L, 8'h00);
      chk($sformatf("fill%0d no issue", b), host_instruction, 8'hFF);
      chk1($sformatf("fill%0d s_ready", b), s_ready, H);
    end
    drive(H, L, 8'h00, L, L, 8'h00);
    chk("gap load issue", host_instruction, 8'h40);
    for (int b = 0; b < N; b++) begin
      drive(H, L, 8'h00, L, L, 8'h00);
      chk($sformatf("gap stream%0d", b), data_in, 8'(8'h05 + b));
    end
    drive(H, L, 8'h00, L, L, 8'h00);
    drive(H, L, 8'h00, L, L, 8'h00);
    chk1("gap load idle", seq_busy, L);

    // ---------------- reset mid-STREAM ----------------
    drive(H, H, 8'h41, L, L, 8'h00);
    drive(H, H, 8'h11, L, L, 8'h00);
    drive(H, H, 8'h22, L, L, 8'h00);
    drive(H, H, 8'h33, L, L, 8'h00);
    drive(H, H, 8'h44, L, L, 8'h00);
    drive(H, L, 8'h00, L, L, 8'h00);
    chk("rst-seq issue", host_instruction, 8'h41);
    drive(H, L, 8'h00, L, L, 8'h00);
    chk("rst-seq stream0", data_in, 8'h11);
    drive(H, L, 8'h00, L, L, 8'h00);
    chk("rst-seq stream1", data_in, 8'h22);
    drive(L, L, 8'h00, L, L, 8'h00);
    chk("in reset data_in", data_in, 8'h00);
    chk("in reset host_instruction", host_instruction, 8'hFF);
    chk1("in reset s_ready", s_ready, L);
    chk1("in reset m_valid", m_valid, L);
    drive(H, L, 8'h00, L, L, 8'h00);
    chk1("post reset s_ready", s_ready, H);
    chk1("post reset seq_busy", seq_busy, L);
    for (int k = 0; k < 3; k++) begin
      drive(H, L, 8'h00, L, L, 8'h00);
      chk($sformatf("post reset%0d host_instruction", k), host_instruction, 8'hFF);
      chk($sformatf("post reset%0d data_in", k), data_in, 8'h00);
    end

    // ---------------- compute with long MAU busy ----------------
    drive(H, H, 8'h01, L, L, 8'h00);
    chk1("compute accept", s_ready, H);
    drive(H, L, 8'h00, L, L, 8'h00);
    chk("compute issue", host_instruction, 8'h01);
    for (int k = 0; k < 10; k++) begin
      drive(H, L, 8'h00, H, L, 8'h00);
      chk1($sformatf("wait%0d seq_busy", k), seq_busy, H);
      chk1($sformatf("wait%0d s_ready", k), s_ready, L);
      chk($sformatf("wait%0d host_instruction", k), host_instruction, 8'hFF);
    end
    drive(H, L, 8'h00, L, L, 8'h00);
    chk("wait release host_instruction", host_instruction, 8'hFF);
    drive(H, L, 8'h00, L, L, 8'h00);
    chk1("compute idle seq_busy", seq_busy, L);
    chk1("compute idle s_ready", s_ready, H);

    // ---------------- random traffic vs reference model ----------------
    // Model: non-NOP instructions are issued in arrival order; a load streams
    // its payload on data_in over the N cycles after issue; a store returns,
    // in order on m_data, the N bytes the MAU presents after its issue.
    for (int t = 0; t < 40; t++) begin
      cls = 2'($urandom_range(0, 3));
      ins = {cls, 6'($urandom)};
      bytes_q.push_back(ins);
      if (cls != 2'b11) exp_issue.push_back(ins);
      if (cls == 2'b01) begin
        for (int b = 0; b < N; b++) begin
          logic [7:0] p;
          p = 8'($urandom);
          bytes_q.push_back(p);
          exp_load.push_back(p);
        end
      end
    end

    pend = 0; mode = 2'b00; fired = 1'b0; done = 1'b0;
    s_valid = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(posedge clk);
      #1;
      busy_flag = ($urandom_range(0, 3) == 0);
      m_ready   = 1'($urandom_range(0, 1));
      data_out  = 8'($urandom);
      if (fired || !s_valid) begin
        s_valid = 1'b0;
        if (bytes_q.size() > 0 && $urandom_range(0, 2) != 0) begin
          s_valid = 1'b1;
          s_data  = bytes_q[0];
        end
      end
      fired = 1'b0;
      @(negedge clk);

      if (s_valid && s_ready) begin
        void'(bytes_q.pop_front());
        fired = 1'b1;
      end

      if (pend > 0) begin
        if (mode == 2'b01) begin
          if (exp_load.size() == 0) chk("rnd load payload underrun", data_in, 8'h00);
          else chk("rnd data_in", data_in, exp_load.pop_front());
        end else begin
          exp_m.push_back(data_out);
        end
        pend--;
      end else begin
        chk("rnd data_in idle", data_in, 8'h00);
      end

      if (host_instruction != 8'hFF) begin
        if (exp_issue.size() == 0) chk("rnd unexpected issue", host_instruction, 8'hFF);
        else chk("rnd issue", host_instruction, exp_issue.pop_front());
        if (host_instruction[7:6] == 2'b01 || host_instruction[7:6] == 2'b10) begin
          mode = host_instruction[7:6];
          pend = N;
        end
      end

      if (m_valid) begin
        if (exp_m.size() == 0) chk1("rnd spurious m_valid", m_valid, L);
        else begin
          chk("rnd m_data", m_data, exp_m[0]);
          if (m_ready) void'(exp_m.pop_front());
        end
      end

      done = (bytes_q.size() == 0) && (exp_issue.size() == 0) && (pend == 0) &&
             (exp_m.size() == 0) && !seq_busy && !s_valid;
    end
    chk1("rnd completed within budget", done, H);
    chk_int("rnd pending issues", exp_issue.size(), 0);
    chk_int("rnd pending load bytes", exp_load.size(), 0);
    chk_int("rnd pending readback bytes", exp_m.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
